// File: rtl/spike_rate_encoder.sv
// Rate encoder: latches a spike count at each window start and spreads exactly
// that many single-cycle spikes evenly across a fixed window of clock cycles.
module spike_rate_encoder #(
    parameter int unsigned CNT_W      = 10,
    parameter int unsigned WIN_CYCLES = 2500,
    parameter int unsigned ACC_W      = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [CNT_W-1:0] rate,
    output logic             spike,
    output logic             active,
    output logic [CNT_W-1:0] emitted,
    output logic             window_done
);

    localparam int unsigned STEP_W = $clog2(WIN_CYCLES + 1);
    localparam logic [ACC_W-1:0]  WIN_A     = ACC_W'(WIN_CYCLES);
    localparam logic [ACC_W-1:0]  HALF_A    = ACC_W'(WIN_CYCLES / 2);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WIN_CYCLES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_nx;
    logic               en_d;
    logic [ACC_W-1:0]   acc, acc_nx;
    logic [ACC_W-1:0]   rate_q, rate_q_nx;
    logic [STEP_W-1:0]  step, step_nx;
    logic               emit_clr, emit_clr_nx;
    logic               spike_nx;
    logic [CNT_W-1:0]   emitted_nx, emit_base;
    logic               done_nx;
    logic               start;
    logic [ACC_W-1:0]   sum;
    logic [ACC_W-1:0]   rate_sat;

    assign start  = en & ~en_d;
    assign active = (state == RUN);
    assign sum    = acc + rate_q;

    always_comb begin
        if (32'(rate) > WIN_CYCLES) rate_sat = WIN_A;
        else                        rate_sat = ACC_W'(rate);
    end

    // An aborted window keeps its count visible for the window_done cycle;
    // emit_clr makes the first step of the new window count up from zero.
    always_comb begin
        state_nx    = state;
        acc_nx      = acc;
        rate_q_nx   = rate_q;
        step_nx     = step;
        emit_clr_nx = emit_clr;
        spike_nx    = 1'b0;
        emitted_nx  = emitted;
        done_nx     = 1'b0;
        emit_base   = emit_clr ? '0 : emitted;
        if (start) begin
            state_nx  = RUN;
            rate_q_nx = rate_sat;
            acc_nx    = HALF_A;
            step_nx   = '0;
            if (state == RUN) begin
                done_nx     = 1'b1;
                emit_clr_nx = 1'b1;
            end else begin
                emitted_nx  = '0;
                emit_clr_nx = 1'b0;
            end
        end else if (state == RUN) begin
            emit_clr_nx = 1'b0;
            if (sum >= WIN_A) begin
                acc_nx     = sum - WIN_A;
                spike_nx   = 1'b1;
                emitted_nx = emit_base + CNT_W'(1);
            end else begin
                acc_nx     = sum;
                emitted_nx = emit_base;
            end
            step_nx = step + STEP_W'(1);
            if (step == LAST_STEP) begin
                state_nx = IDLE;
                done_nx  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            en_d        <= 1'b1;
            acc         <= '0;
            rate_q      <= '0;
            step        <= '0;
            emit_clr    <= 1'b0;
            spike       <= 1'b0;
            emitted     <= '0;
            window_done <= 1'b0;
        end else begin
            state       <= state_nx;
            en_d        <= en;
            acc         <= acc_nx;
            rate_q      <= rate_q_nx;
            step        <= step_nx;
            emit_clr    <= emit_clr_nx;
            spike       <= spike_nx;
            emitted     <= emitted_nx;
            window_done <= done_nx;
        end
    end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Bench for spike_rate_encoder: closed-form window model checked every cycle,
// directed windows with literal spike patterns, and a long-window count-back.
module tb_spike_rate_encoder;

    localparam int W  = 10;
    localparam int BW = 2500;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0, en2 = 1'b0;
    logic [9:0] rate = '0, rate2 = '0;
    logic       spike, active, window_done;
    logic [9:0] emitted;
    logic       spike2, active2, window_done2;
    logic [9:0] emitted2;

    int vectors = 0;
    int errors  = 0;
    bit chk_on  = 1'b0;

    always #5 clk = ~clk;

    spike_rate_encoder #(.CNT_W(10), .WIN_CYCLES(W), .ACC_W(5)) dut (
        .clk(clk), .reset(reset), .en(en), .rate(rate), .spike(spike),
        .active(active), .emitted(emitted), .window_done(window_done)
    );

    spike_rate_encoder #(.CNT_W(10), .WIN_CYCLES(BW), .ACC_W(12)) dut_big (
        .clk(clk), .reset(reset), .en(en2), .rate(rate2), .spike(spike2),
        .active(active2), .emitted(emitted2), .window_done(window_done2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Cumulative spikes after step k: floor((W/2 + k*N) / W).
    function automatic int cum(input int k, input int n);
        return (W / 2 + k * n) / W;
    endfunction

    int m_k, m_n, m_emitted;
    bit m_prev, m_spike, m_active, m_done;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_prev = 1'b1; m_spike = 1'b0; m_active = 1'b0; m_done = 1'b0;
            m_emitted = 0; m_k = W; m_n = 0;
        end else begin
            if (en && !m_prev) begin
                m_done = m_active;
                if (!m_active) m_emitted = 0;
                m_spike  = 1'b0;
                m_active = 1'b1;
                m_k      = 0;
                m_n      = (int'(rate) > W) ? W : int'(rate);
            end else if (m_active) begin
                m_k++;
                m_spike   = cum(m_k, m_n) > cum(m_k - 1, m_n);
                m_emitted = cum(m_k, m_n);
                m_done    = (m_k == W);
                m_active  = (m_k != W);
            end else begin
                m_spike = 1'b0;
                m_done  = 1'b0;
            end
            m_prev = en;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("spike", 32'(spike), 32'(m_spike));
            check("active", 32'(active), 32'(m_active));
            check("emitted", 32'(emitted), 32'(m_emitted));
            check("window_done", 32'(window_done), 32'(m_done));
        end
    end

    task automatic start_win(input logic [9:0] r);
        en = 1'b1;
        rate = r;
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic steps(input int n, input logic [9:0] mid_rate, output logic [9:0] pat);
        pat = '0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            pat[k-1] = spike;
            if (k == 3) rate = mid_rate;
        end
    endtask

    task automatic end_checks(input string tag, input logic [9:0] pat, input logic [9:0] exp_pat,
                              input int exp_emitted);
        check({tag, "_pattern"}, 32'(pat), 32'(exp_pat));
        check({tag, "_done"}, 32'(window_done), 32'd1);
        check({tag, "_emitted"}, 32'(emitted), 32'(exp_emitted));
        check({tag, "_active"}, 32'(active), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic big_window();
        int cnt, dones;
        en2 = 1'b1;
        @(negedge clk);
        en2 = 1'b0;
        cnt = 0;
        dones = 0;
        repeat (BW + 100) begin
            @(negedge clk);
            cnt += int'(spike2);
            dones += int'(window_done2);
        end
        check("big_count", 32'(cnt), 32'd7);
        check("big_emitted", 32'(emitted2), 32'd7);
        check("big_done_pulses", 32'(dones), 32'd1);
        check("big_active", 32'(active2), 32'd0);
    endtask

    logic [9:0] pat;

    initial begin
        en = 1'b1;
        rate = 10'd5;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("held_en_spike", 32'(spike), 32'd0);
        check("held_en_active", 32'(active), 32'd0);
        en = 1'b0;
        @(negedge clk);

        start_win(10'd5);
        steps(W, 10'd5, pat);
        end_checks("rate5", pat, 10'b0101010101, 5);

        start_win(10'd0);
        steps(W, 10'd0, pat);
        end_checks("rate0", pat, 10'b0000000000, 0);

        start_win(10'd10);
        steps(W, 10'd10, pat);
        end_checks("rate10", pat, 10'b1111111111, 10);

        start_win(10'd13);
        steps(W, 10'd2, pat);
        end_checks("rate13", pat, 10'b1111111111, 10);

        // Second strobe edge lands on step 6.
        start_win(10'd5);
        steps(5, 10'd5, pat);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        check("abort_done", 32'(window_done), 32'd1);
        check("abort_emitted", 32'(emitted), 32'd3);
        check("abort_spike", 32'(spike), 32'd0);
        steps(W, 10'd5, pat);
        end_checks("restart", pat, 10'b0101010101, 5);

        start_win(10'd5);
        steps(4, 10'd5, pat);
        #2 reset = 1'b0;
        #1;
        check("async_spike", 32'(spike), 32'd0);
        check("async_active", 32'(active), 32'd0);
        check("async_emitted", 32'(emitted), 32'd0);
        en = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset_active", 32'(active), 32'd0);
        en = 1'b0;
        @(negedge clk);
        start_win(10'd5);
        steps(W, 10'd5, pat);
        end_checks("after_reset", pat, 10'b0101010101, 5);

        rate2 = 10'd7;
        repeat (3) big_window();

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
